mem_access: RTL and testbench

- Memory-access (MA) pipeline stage. It consumes the EX/MA register outputs: pc, rd, ALU result used as the address, store data, and the load/store op decode.
- It issues one data-bus transaction per load/store over a req/gnt + rvalid handshake.
- Loads are sign/zero-extended. Store data is aligned with byte strobes. Misaligned accesses raise a fault.
- Back-pressures the pipeline with stall_req and drives the MA/WB register.

---
 rtl/ma_pkg.sv | 33 +++
 rtl/lsu_align.sv | 59 +++++
 rtl/mem_access.sv | 189 ++++++++++++++++++
 tb/tb_mem_access.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ma_pkg.sv
// Shared types for the memory-access stage: size codes, fault causes,
// FSM states and the transaction record captured at issue time.
package ma_pkg;

    localparam int MA_XLEN = 64;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [1:0] FC_LD_MIS = 2'd0;
    localparam logic [1:0] FC_ST_MIS = 2'd1;
    localparam logic [1:0] FC_LD_ACC = 2'd2;
    localparam logic [1:0] FC_ST_ACC = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } ma_state_e;

    typedef struct packed {
        logic [MA_XLEN-1:0] addr;
        logic [MA_XLEN-1:0] data;
        logic [MA_XLEN-1:0] pc;
        logic [4:0]         rd;
        logic [1:0]         size;
        logic               uns;
        logic               we;
    } ma_txn_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store strobes/data, misalign detect, load extract.
// Ports: off/size/ld_unsigned select the lane; st_data/rdata in;
// misalign, wstrb, wdata, ld_data out. Purely combinational.
module lsu_align
    import ma_pkg::*;
#(
    parameter int XLEN   = MA_XLEN,
    parameter int STRB_W = XLEN / 8
) (
    input  logic [2:0]        off,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    input  logic [XLEN-1:0]   st_data,
    input  logic [XLEN-1:0]   rdata,
    output logic              misalign,
    output logic [STRB_W-1:0] wstrb,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN-1:0]   ld_data
);

    logic [5:0]        sh;
    logic [XLEN-1:0]   rsh;
    logic [STRB_W-1:0] base;
    logic              sx;

    assign sh    = {off, 3'b000};
    assign wdata = st_data << sh;
    assign rsh   = rdata >> sh;
    assign sx    = ~ld_unsigned;
    assign wstrb = base << off;

    always_comb begin
        base     = '0;
        misalign = 1'b0;
        ld_data  = '0;
        unique case (size)
            SZ_B: begin
                base    = STRB_W'(8'h01);
                ld_data = {{(XLEN-8){sx & rsh[7]}}, rsh[7:0]};
            end
            SZ_H: begin
                base     = STRB_W'(8'h03);
                misalign = off[0];
                ld_data  = {{(XLEN-16){sx & rsh[15]}}, rsh[15:0]};
            end
            SZ_W: begin
                base     = STRB_W'(8'h0F);
                misalign = |off[1:0];
                ld_data  = {{(XLEN-32){sx & rsh[31]}}, rsh[31:0]};
            end
            SZ_D: begin
                base     = '1;
                misalign = |off;
                ld_data  = rsh;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: one bus transaction per load/store,
// stalls upstream until the response, and drives the MA/WB register.
// Ports: EX/MA inputs (valid_in, pc_in, rd_in, result_in, data2_in,
// ld_en, st_en, size, ld_unsigned, clear); bus req/gnt/rvalid channel;
// stall_req; registered fault/fault_cause/fault_addr; MA/WB outputs
// pc_out, rd_out, wb_data, wb_en. fault is registered with MA/WB, so
// it pulses in the cycle after the faulting instruction leaves MA.
module mem_access
    import ma_pkg::*;
#(
    parameter int XLEN   = MA_XLEN,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              valid_in,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [4:0]        rd_in,
    input  logic [XLEN-1:0]   result_in,
    input  logic [XLEN-1:0]   data2_in,
    input  logic              ld_en,
    input  logic              st_en,
    input  logic [1:0]        size,
    input  logic              ld_unsigned,
    output logic              bus_req,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    input  logic              bus_err,
    output logic              stall_req,
    output logic              fault,
    output logic [1:0]        fault_cause,
    output logic [XLEN-1:0]   fault_addr,
    output logic [XLEN-1:0]   pc_out,
    output logic [4:0]        rd_out,
    output logic [XLEN-1:0]   wb_data,
    output logic              wb_en
);

    ma_state_e state_q, state_d;
    ma_txn_t   txn_q;
    logic      kill_q;

    logic              live;
    logic [XLEN-1:0]   s_addr;
    logic [XLEN-1:0]   s_data;
    logic [1:0]        s_size;
    logic              s_uns;
    logic              s_we;
    logic              misalign;
    logic [STRB_W-1:0] al_wstrb;
    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_ld;
    logic              mem_op;
    logic              issue;
    logic              done;

    // The aligner sees live inputs while idle and the captured
    // transaction otherwise, so REQ fields stay stable and the
    // response never depends on what upstream is presenting.
    assign live   = (state_q == IDLE);
    assign s_addr = live ? result_in   : txn_q.addr;
    assign s_data = live ? data2_in    : txn_q.data;
    assign s_size = live ? size        : txn_q.size;
    assign s_uns  = live ? ld_unsigned : txn_q.uns;
    assign s_we   = live ? st_en       : txn_q.we;

    lsu_align #(
        .XLEN   (XLEN),
        .STRB_W (STRB_W)
    ) u_align (
        .off         (s_addr[2:0]),
        .size        (s_size),
        .ld_unsigned (s_uns),
        .st_data     (s_data),
        .rdata       (bus_rdata),
        .misalign    (misalign),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .ld_data     (al_ld)
    );

    assign mem_op = valid_in & (ld_en | st_en);
    assign issue  = live & mem_op & ~misalign & ~clear & ~rst;
    assign done   = (state_q == RESP) & bus_rvalid;

    always_comb begin
        state_d   = state_q;
        bus_req   = 1'b0;
        stall_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    bus_req   = 1'b1;
                    stall_req = 1'b1;
                    state_d   = bus_gnt ? RESP : REQ;
                end
            end
            REQ: begin
                bus_req   = 1'b1;
                stall_req = 1'b1;
                if (bus_gnt) state_d = RESP;
            end
            RESP: begin
                stall_req = ~bus_rvalid;
                if (bus_rvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            bus_req   = 1'b0;
            stall_req = 1'b0;
        end
    end

    assign bus_we    = bus_req & s_we;
    assign bus_addr  = bus_req ? {s_addr[XLEN-1:3], 3'b000} : '0;
    assign bus_wdata = bus_we ? al_wdata : '0;
    assign bus_wstrb = bus_we ? al_wstrb : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            txn_q       <= '0;
            kill_q      <= 1'b0;
            pc_out      <= '0;
            rd_out      <= '0;
            wb_data     <= '0;
            wb_en       <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= '0;
            fault_addr  <= '0;
        end else begin
            state_q     <= state_d;
            pc_out      <= '0;
            rd_out      <= '0;
            wb_data     <= '0;
            wb_en       <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= '0;
            fault_addr  <= '0;

            if (issue) begin
                txn_q.addr <= result_in;
                txn_q.data <= data2_in;
                txn_q.pc   <= pc_in;
                txn_q.rd   <= rd_in;
                txn_q.size <= size;
                txn_q.uns  <= ld_unsigned;
                txn_q.we   <= st_en;
                kill_q     <= 1'b0;
            end else if (!live && clear) begin
                // A flush mid-transaction squashes the result once
                // the bus side has finished.
                kill_q <= 1'b1;
            end

            if (live) begin
                if (valid_in && !clear && !mem_op) begin
                    pc_out  <= pc_in;
                    rd_out  <= rd_in;
                    wb_data <= result_in;
                    wb_en   <= (rd_in != 5'd0);
                end else if (valid_in && !clear && misalign) begin
                    fault       <= 1'b1;
                    fault_cause <= st_en ? FC_ST_MIS : FC_LD_MIS;
                    fault_addr  <= result_in;
                end
            end else if (done && !kill_q && !clear) begin
                pc_out <= txn_q.pc;
                rd_out <= txn_q.rd;
                if (bus_err) begin
                    fault       <= 1'b1;
                    fault_cause <= txn_q.we ? FC_ST_ACC : FC_LD_ACC;
                    fault_addr  <= txn_q.addr;
                end else if (!txn_q.we) begin
                    wb_data <= al_ld;
                    wb_en   <= (txn_q.rd != 5'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomised bench for mem_access with a byte-level reference model
// and a bus responder driven per instruction.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        valid_in;
    logic [63:0] pc_in;
    logic [4:0]  rd_in;
    logic [63:0] result_in;
    logic [63:0] data2_in;
    logic        ld_en;
    logic        st_en;
    logic [1:0]  size;
    logic        ld_unsigned;
    logic        bus_req;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic        bus_err;
    logic        stall_req;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [63:0] fault_addr;
    logic [63:0] pc_out;
    logic [4:0]  rd_out;
    logic [63:0] wb_data;
    logic        wb_en;

    always #5 clk = ~clk;

    mem_access dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .valid_in    (valid_in),
        .pc_in       (pc_in),
        .rd_in       (rd_in),
        .result_in   (result_in),
        .data2_in    (data2_in),
        .ld_en       (ld_en),
        .st_en       (st_en),
        .size        (size),
        .ld_unsigned (ld_unsigned),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_wstrb   (bus_wstrb),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata),
        .bus_err     (bus_err),
        .stall_req   (stall_req),
        .fault       (fault),
        .fault_cause (fault_cause),
        .fault_addr  (fault_addr),
        .pc_out      (pc_out),
        .rd_out      (rd_out),
        .wb_data     (wb_data),
        .wb_en       (wb_en)
    );

    int checks = 0;
    int errors = 0;

    // Expected MA/WB + fault contents for the next sampled cycle.
    logic        p_en;
    logic        p_fault;
    logic [1:0]  p_cause;
    logic [63:0] p_faddr;
    logic [63:0] p_pc;
    logic [63:0] p_data;
    logic [4:0]  p_rd;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic set_bubble();
        p_en    = 1'b0;
        p_fault = 1'b0;
        p_cause = 2'd0;
        p_faddr = '0;
        p_pc    = '0;
        p_data  = '0;
        p_rd    = '0;
    endtask

    task automatic chk_wb();
        chk("wb_en", 64'(wb_en), 64'(p_en));
        chk("fault", 64'(fault), 64'(p_fault));
        if (p_en) begin
            chk("pc_out", pc_out, p_pc);
            chk("rd_out", 64'(rd_out), 64'(p_rd));
            chk("wb_data", wb_data, p_data);
        end
        if (p_fault) begin
            chk("fault_cause", 64'(fault_cause), 64'(p_cause));
            chk("fault_addr", fault_addr, p_faddr);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Upstream presents garbage while stalled; the stage must not care.
    task automatic scramble();
        int k;
        pc_in       = rnd64();
        rd_in       = 5'($urandom);
        result_in   = rnd64();
        data2_in    = rnd64();
        size        = 2'($urandom);
        ld_unsigned = 1'($urandom);
        k           = $urandom_range(0, 2);
        ld_en       = (k == 1);
        st_en       = (k == 2);
        valid_in    = 1'($urandom);
    endtask

    task automatic do_op(
        input logic        v,
        input logic        ld,
        input logic        st,
        input logic [1:0]  sz,
        input logic        uns,
        input logic [63:0] addr,
        input logic [63:0] d2,
        input logic [63:0] pc,
        input logic [4:0]  rd,
        input int          gd,
        input int          rdl,
        input logic        err,
        input logic [63:0] rdat,
        input int          clr_cyc
    );
        int          nb;
        int          off;
        int          last;
        logic        mem;
        logic        mis;
        logic        iss;
        logic        resp;
        logic [15:0] s16;
        logic [7:0]  strb;
        logic [63:0] wd;
        logic [63:0] sh;
        logic [63:0] mask;
        logic [63:0] lv;

        nb   = 1 << sz;
        off  = int'(addr[2:0]);
        mem  = v && (ld || st);
        mis  = mem && ((addr % 64'(nb)) != 0);
        iss  = mem && !mis && (clr_cyc != 0);
        last = gd + 1 + rdl;
        s16  = ((16'd1 << nb) - 16'd1) << off;
        strb = s16[7:0];
        wd   = d2 << (8 * off);
        sh   = rdat >> (8 * off);
        mask = (nb == 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
        lv   = sh & mask;
        if (!uns && lv[8*nb-1]) lv = lv | ~mask;

        @(posedge clk); #1;
        valid_in    = v;
        ld_en       = ld;
        st_en       = st;
        size        = sz;
        ld_unsigned = uns;
        result_in   = addr;
        data2_in    = d2;
        pc_in       = pc;
        rd_in       = rd;
        clear       = (clr_cyc == 0);
        bus_gnt     = iss && (gd == 0);
        bus_rvalid  = 1'($urandom);
        bus_err     = 1'($urandom);
        bus_rdata   = rnd64();
        @(negedge clk);
        chk_wb();
        chk("bus_req0", 64'(bus_req), 64'(iss));
        chk("stall0", 64'(stall_req), 64'(iss));
        if (iss) begin
            chk("addr0", bus_addr, addr & ~64'h7);
            chk("we0", 64'(bus_we), 64'(st));
            if (st) begin
                chk("wstrb0", 64'(bus_wstrb), 64'(strb));
                chk("wdata0", bus_wdata, wd);
            end
        end

        set_bubble();
        if (v && clr_cyc != 0 && !ld && !st) begin
            p_en   = (rd != 0);
            p_pc   = pc;
            p_rd   = rd;
            p_data = addr;
        end else if (mis && clr_cyc != 0) begin
            p_fault = 1'b1;
            p_cause = st ? 2'd1 : 2'd0;
            p_faddr = addr;
        end

        if (iss) begin
            for (int c = 1; c <= last; c++) begin
                @(posedge clk); #1;
                scramble();
                resp       = (c == last);
                clear      = (clr_cyc == c);
                bus_gnt    = (c == gd);
                bus_rvalid = resp ? 1'b1 : ((c <= gd) ? 1'($urandom) : 1'b0);
                bus_err    = resp ? err : 1'($urandom);
                bus_rdata  = resp ? rdat : rnd64();
                @(negedge clk);
                chk_wb();
                chk("bus_req", 64'(bus_req), 64'(c <= gd));
                chk("stall", 64'(stall_req), 64'(!resp));
                if (c <= gd) begin
                    chk("addr", bus_addr, addr & ~64'h7);
                    chk("we", 64'(bus_we), 64'(st));
                    if (st) begin
                        chk("wstrb", 64'(bus_wstrb), 64'(strb));
                        chk("wdata", bus_wdata, wd);
                    end
                end
            end
            if (clr_cyc < 1 || clr_cyc > last) begin
                if (err) begin
                    p_fault = 1'b1;
                    p_cause = st ? 2'd3 : 2'd2;
                    p_faddr = addr;
                end else if (ld) begin
                    p_en   = (rd != 0);
                    p_pc   = pc;
                    p_rd   = rd;
                    p_data = lv;
                end
            end
        end
    endtask

    task automatic idle_op();
        do_op(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0, 5'd0,
              0, 0, 1'b0, '0, -1);
    endtask

    initial begin
        int          k;
        int          gd;
        int          rdl;
        int          cc;
        logic [1:0]  sz;
        logic [63:0] a;

        rst = 1'b1; clear = 1'b0; valid_in = 1'b0; pc_in = '0;
        rd_in = '0; result_in = '0; data2_in = '0; ld_en = 1'b0;
        st_en = 1'b0; size = '0; ld_unsigned = 1'b0; bus_gnt = 1'b0;
        bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
        set_bubble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 64'(bus_req), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_wb_en", 64'(wb_en), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_pc", pc_out, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Signed byte load, gnt immediately, rvalid two cycles later.
        do_op(1, 1, 0, 2'd0, 0, 64'h1003, '0, 64'h100, 5'd1,
              0, 1, 0, 64'h0000_0000_8000_0000, -1);
        // Halfword store with grant held off three cycles.
        do_op(1, 0, 1, 2'd1, 0, 64'h2006, 64'h1234, 64'h104, 5'd2,
              3, 0, 0, '0, -1);
        // Misaligned word load.
        do_op(1, 1, 0, 2'd2, 0, 64'h3002, '0, 64'h108, 5'd3,
              0, 0, 0, '0, -1);
        // Doubleword load with access error.
        do_op(1, 1, 0, 2'd3, 0, 64'h4000, '0, 64'h10c, 5'd4,
              0, 0, 1, rnd64(), -1);
        // Flush arriving the cycle after grant.
        do_op(1, 1, 0, 2'd3, 0, 64'h5000, '0, 64'h110, 5'd6,
              0, 1, 0, rnd64(), 1);
        // ALU result then unsigned word load, back to back.
        do_op(1, 0, 0, 2'd0, 0, 64'h7, '0, 64'h114, 5'd5,
              0, 0, 0, '0, -1);
        do_op(1, 1, 0, 2'd2, 1, 64'h6004, '0, 64'h118, 5'd7,
              0, 0, 0, 64'hDEAD_BEEF_0000_0000, -1);
        // ALU writing x0, and a flushed load in idle.
        do_op(1, 0, 0, 2'd0, 0, 64'h55, '0, 64'h11c, 5'd0,
              0, 0, 0, '0, -1);
        do_op(1, 1, 0, 2'd0, 0, 64'h7000, '0, 64'h120, 5'd8,
              0, 0, 0, '0, 0);
        idle_op();

        // Reset while a request is still waiting for grant.
        @(posedge clk); #1;
        valid_in = 1; ld_en = 1; st_en = 0; size = 2'd3;
        result_in = 64'h8000; clear = 0; bus_gnt = 0; bus_rvalid = 0;
        @(negedge clk);
        chk("mid_req0", 64'(bus_req), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req1", 64'(bus_req), 64'd1);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("mid_rst_req", 64'(bus_req), 64'd0);
        chk("mid_rst_stall", 64'(stall_req), 64'd0);
        @(posedge clk); #1;
        rst = 0; valid_in = 0; ld_en = 0;
        @(negedge clk);
        chk("post_rst_req", 64'(bus_req), 64'd0);
        chk("post_rst_stall", 64'(stall_req), 64'd0);
        set_bubble();

        for (int i = 0; i < 300; i++) begin
            k   = $urandom_range(0, 2);
            sz  = 2'($urandom);
            a   = rnd64();
            if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << sz) - 1);
            gd  = $urandom_range(0, 3);
            rdl = $urandom_range(0, 2);
            cc  = -1;
            if ($urandom_range(0, 9) == 0)
                cc = $urandom_range(0, gd + 1 + rdl);
            do_op(1'($urandom_range(0, 9) != 0), k == 1, k == 2, sz,
                  1'($urandom), a, rnd64(), rnd64(), 5'($urandom),
                  gd, rdl, $urandom_range(0, 7) == 0, rnd64(), cc);
        end
        idle_op();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
